vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Single-port framebuffer arbiter between the VGA scanout path and a CPU-side requester.
- The VGA controller issues per-pixel read requests; these always have priority.
- The CPU gets read/write access in any cycle the display does not use.
- A built-in clear engine fills the framebuffer with a colour in the cycles the display leaves free.
- Sits between vga_ctrl and the framebuffer RAM: vga_ctrl -> arbiter -> RAM.

Parameters:
- H_RES, 640, active pixels per line; linear address = v*H_RES + h.
- V_RES, 480, active lines.
- ADDR_W, 19, framebuffer word address width; H_RES*V_RES must be <= 2^ADDR_W.
- DATA_W, 24, pixel width (RGB888).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display needs the pixel at (disp_h_addr, disp_v_addr) this cycle
- disp_h_addr  in  10  pixel column
- disp_v_addr  in  10  pixel row
- disp_data  out  DATA_W  pixel returned one cycle after disp_req
- disp_data_valid  out  1  disp_data qualifier
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  CPU request accepted this cycle (valid && ready)
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_W  linear word address
- cpu_req_wdata  in  DATA_W  write data
- cpu_rsp_valid  out  1  read data valid
- cpu_rsp_data  out  DATA_W  read data
- cpu_err  out  1  one-cycle pulse when an accepted request was out of range
- clear_start  in  1  pulse; start a fill with clear_color
- clear_color  in  DATA_W  fill value, sampled on the start pulse
- clear_busy  out  1  fill in progress
- clear_done  out  1  one-cycle pulse when the last word is written
- cpu_stall_cnt  out  16  saturating count of cycles with cpu_req_valid && !cpu_req_ready
- mem_en, mem_we  out  1  RAM port controls
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; registered, 1-cycle latency

Behaviour:
- Reset: every output 0, state IDLE, clear counter 0, stall counter 0, read-owner tag NONE.
- Address calculation: display address = (v<<9)+(v<<7)+h at the default H_RES; otherwise v*H_RES+h.
- Display range check: h>=H_RES or v>=V_RES is out of range. An out-of-range display request does no RAM access, but disp_data_valid still pulses next cycle with disp_data=0.
- CPU range check: cpu_req_addr >= H_RES*V_RES is out of range. The request is still accepted; a write is dropped; a read returns cpu_rsp_valid with data 0. cpu_err pulses in the cycle after acceptance.
- Priority in each cycle is display > clear engine > CPU. The display is never stalled.
- cpu_req_ready = (state==IDLE) && !disp_req. It is combinational from disp_req and the state.
- Read latency: a display or CPU read granted in cycle N gives disp_data_valid / cpu_rsp_valid in cycle N+1 with data = mem_rdata. Steering uses a registered owner tag (NONE/DISP/CPU).
- A CPU write is granted and committed in the same cycle, with no response.
- FSM IDLE: clear_start -> CLEAR. Latch clear_color, clear counter=0, clear_busy=1.
- FSM CLEAR: in each cycle without disp_req, write clear_color at the counter address and increment the counter. The write to address H_RES*V_RES-1 pulses clear_done and returns to IDLE next cycle with clear_busy=0.
- clear_start while in CLEAR is ignored.
- Simultaneous events:
  - disp_req and cpu_req_valid together: display granted; the CPU request must hold.
  - clear_start and cpu_req_valid in the same IDLE cycle: the CPU request is granted that cycle (if no disp_req), and CLEAR starts next cycle.
  - A CPU request held through a CLEAR is accepted only after it ends.
- cpu_stall_cnt saturates at 16'hFFFF and is cleared only by reset.
- Reset mid-CLEAR aborts the fill: no clear_done, the RAM is left partially filled, and the pending read response is dropped.

Decomposition:
- Package fb_pkg holds H_RES, V_RES, FB_DEPTH (=H_RES*V_RES), the pixel_t typedef, the state enum (IDLE, CLEAR) and the owner enum (NONE, DISP, CPU).
- Sub-module fb_addr_calc: combinational (h, v) -> linear address plus in-range flag.
- fb_addr_calc is instantiated for the display path; the CPU range check is a compare against FB_DEPTH.

Test Plan:
- Display read (h=5, v=2) with RAM[1285]=24'hABCDEF -> next cycle disp_data_valid=1, disp_data=24'hABCDEF; mem_addr=1285 in the request cycle.
- disp_req and CPU write (addr 10, data 24'h123456) in the same cycle -> cpu_req_ready=0 and cpu_stall_cnt=1. With disp_req low the next cycle -> write accepted, RAM[10]=24'h123456.
- CPU write addr 307200 -> accepted, no RAM write, cpu_err pulse next cycle. CPU read at 307200 -> cpu_rsp_data=0. Display (h=640, v=0) -> disp_data=0, no mem_en.
- clear_start with color 24'h00FF00 and disp_req asserted every other cycle -> clear_busy high for 614400 cycles, and clear_done pulses exactly once. Spot reads give RAM[0]=RAM[307199]=24'h00FF00, and cpu_req_ready=0 throughout.
- Reset asserted at clear counter 1000 -> clear_busy=0 next cycle, no clear_done pulse, RAM[1000] keeps its old value, all outputs 0.
- Hold cpu_req_valid with disp_req high for 70000 cycles -> cpu_stall_cnt=16'hFFFF (saturated), with no wrap.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel type and arbiter state encodings.
package fb_pkg;
    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned FB_DEPTH = H_RES * V_RES;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 24;
    localparam int unsigned COORD_W  = 10;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        DISP,
        CPU
    } owner_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Maps a display (h, v) coordinate to a linear framebuffer word address.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int unsigned H_RES = fb_pkg::H_RES,
    parameter int unsigned V_RES = fb_pkg::V_RES
) (
    input  logic [COORD_W-1:0] h,
    input  logic [COORD_W-1:0] v,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    // 640 = 512 + 128, so the default geometry needs no multiplier
    generate
        if (H_RES == 640) begin : g_shift
            assign addr = (ADDR_W'(v) << 9) + (ADDR_W'(v) << 7) + ADDR_W'(h);
        end else begin : g_mult
            assign addr = ADDR_W'(v) * ADDR_W'(H_RES) + ADDR_W'(h);
        end
    endgenerate

    assign in_range = (32'(h) < H_RES) && (32'(v) < V_RES);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear-engine fill > CPU access.
module vga_fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned H_RES = fb_pkg::H_RES,
    parameter int unsigned V_RES = fb_pkg::V_RES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_req,
    input  logic [COORD_W-1:0] disp_h_addr,
    input  logic [COORD_W-1:0] disp_v_addr,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_data_valid,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic               cpu_req_we,
    input  logic [ADDR_W-1:0]  cpu_req_addr,
    input  logic [DATA_W-1:0]  cpu_req_wdata,
    output logic               cpu_rsp_valid,
    output logic [DATA_W-1:0]  cpu_rsp_data,
    output logic               cpu_err,
    input  logic               clear_start,
    input  logic [DATA_W-1:0]  clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [15:0]        cpu_stall_cnt,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int unsigned        FB_WORDS  = H_RES * V_RES;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    state_t              state;
    owner_t              owner;
    logic [ADDR_W-1:0]   clr_cnt;
    pixel_t              clr_color;
    logic [ADDR_W-1:0]   disp_addr;
    logic                disp_in_range;
    logic                cpu_in_range;
    logic                disp_fire;
    logic                clr_fire;
    logic                cpu_fire;

    fb_addr_calc #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_disp_addr (
        .h        (disp_h_addr),
        .v        (disp_v_addr),
        .addr     (disp_addr),
        .in_range (disp_in_range)
    );

    assign cpu_in_range  = 32'(cpu_req_addr) < FB_WORDS;
    assign cpu_req_ready = !reset && (state == IDLE) && !disp_req;
    assign cpu_fire      = cpu_req_valid && cpu_req_ready;
    assign clr_fire      = !reset && (state == CLEAR) && !disp_req;
    assign disp_fire     = !reset && disp_req && disp_in_range;

    // Read data is steered by who owned the port in the previous cycle
    assign disp_data    = (owner == DISP) ? mem_rdata : '0;
    assign cpu_rsp_data = (owner == CPU)  ? mem_rdata : '0;

    // RAM port mux; out-of-range requests never reach the RAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_fire) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (clr_fire) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = clr_color;
        end else if (cpu_fire && cpu_in_range) begin
            mem_en    = 1'b1;
            mem_we    = cpu_req_we;
            mem_addr  = cpu_req_addr;
            mem_wdata = cpu_req_we ? cpu_req_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= NONE;
            clr_cnt         <= '0;
            clr_color       <= '0;
            clear_busy      <= 1'b0;
            clear_done      <= 1'b0;
            disp_data_valid <= 1'b0;
            cpu_rsp_valid   <= 1'b0;
            cpu_err         <= 1'b0;
            cpu_stall_cnt   <= '0;
        end else begin
            clear_done      <= 1'b0;
            disp_data_valid <= disp_req;
            cpu_rsp_valid   <= cpu_fire && !cpu_req_we;
            cpu_err         <= cpu_fire && !cpu_in_range;

            if (disp_fire) begin
                owner <= DISP;
            end else if (cpu_fire && !cpu_req_we && cpu_in_range) begin
                owner <= CPU;
            end else begin
                owner <= NONE;
            end

            if (cpu_req_valid && !cpu_req_ready && (cpu_stall_cnt != 16'hFFFF)) begin
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clr_color  <= clear_color;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_fire) begin
                        if (clr_cnt == LAST_ADDR) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench: full-size arbiter plus a tiny-geometry copy for a complete fill.
module tb_vga_fb_arbiter;
    import fb_pkg::*;

    localparam int unsigned S_H     = 8;
    localparam int unsigned S_V     = 4;
    localparam int unsigned S_DEPTH = S_H * S_V;
    localparam logic [23:0] GREEN   = 24'h00FF00;

    logic               clk = 1'b0;
    logic               reset;
    logic               disp_req;
    logic [COORD_W-1:0] disp_h;
    logic [COORD_W-1:0] disp_v;
    logic               cpu_valid;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               clear_start;
    logic [DATA_W-1:0]  clear_color;

    logic [DATA_W-1:0]  b_disp_data, s_disp_data;
    logic               b_disp_valid, s_disp_valid;
    logic               b_cpu_ready, s_cpu_ready;
    logic               b_rsp_valid, s_rsp_valid;
    logic [DATA_W-1:0]  b_rsp_data, s_rsp_data;
    logic               b_cpu_err, s_cpu_err;
    logic               b_clear_busy, s_clear_busy;
    logic               b_clear_done, s_clear_done;
    logic [15:0]        b_stall, s_stall;
    logic               b_mem_en, s_mem_en;
    logic               b_mem_we, s_mem_we;
    logic [ADDR_W-1:0]  b_mem_addr, s_mem_addr;
    logic [DATA_W-1:0]  b_mem_wdata, s_mem_wdata;
    logic [DATA_W-1:0]  b_mem_rdata, s_mem_rdata;

    logic [DATA_W-1:0]  ram_b [FB_DEPTH];
    logic [DATA_W-1:0]  ram_s [S_DEPTH];

    logic [DATA_W-1:0]  disp_q[$];
    logic [DATA_W-1:0]  cpu_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int s_busy_cycles = 0, s_done_cnt = 0, s_ready_busy = 0;
    int b_done_cnt = 0, b_ready_busy = 0, b_clr_writes = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk (clk), .reset (reset),
        .disp_req (disp_req), .disp_h_addr (disp_h), .disp_v_addr (disp_v),
        .disp_data (b_disp_data), .disp_data_valid (b_disp_valid),
        .cpu_req_valid (cpu_valid), .cpu_req_ready (b_cpu_ready), .cpu_req_we (cpu_we),
        .cpu_req_addr (cpu_addr), .cpu_req_wdata (cpu_wdata),
        .cpu_rsp_valid (b_rsp_valid), .cpu_rsp_data (b_rsp_data), .cpu_err (b_cpu_err),
        .clear_start (clear_start), .clear_color (clear_color),
        .clear_busy (b_clear_busy), .clear_done (b_clear_done), .cpu_stall_cnt (b_stall),
        .mem_en (b_mem_en), .mem_we (b_mem_we), .mem_addr (b_mem_addr),
        .mem_wdata (b_mem_wdata), .mem_rdata (b_mem_rdata)
    );

    vga_fb_arbiter #(.H_RES(S_H), .V_RES(S_V)) dut_small (
        .clk (clk), .reset (reset),
        .disp_req (disp_req), .disp_h_addr (disp_h), .disp_v_addr (disp_v),
        .disp_data (s_disp_data), .disp_data_valid (s_disp_valid),
        .cpu_req_valid (cpu_valid), .cpu_req_ready (s_cpu_ready), .cpu_req_we (cpu_we),
        .cpu_req_addr (cpu_addr), .cpu_req_wdata (cpu_wdata),
        .cpu_rsp_valid (s_rsp_valid), .cpu_rsp_data (s_rsp_data), .cpu_err (s_cpu_err),
        .clear_start (clear_start), .clear_color (clear_color),
        .clear_busy (s_clear_busy), .clear_done (s_clear_done), .cpu_stall_cnt (s_stall),
        .mem_en (s_mem_en), .mem_we (s_mem_we), .mem_addr (s_mem_addr),
        .mem_wdata (s_mem_wdata), .mem_rdata (s_mem_rdata)
    );

    // Registered-read RAMs behind each arbiter
    always @(posedge clk) begin
        if (b_mem_en && (32'(b_mem_addr) < FB_DEPTH)) begin
            if (b_mem_we) ram_b[int'(b_mem_addr)] <= b_mem_wdata;
            else          b_mem_rdata <= ram_b[int'(b_mem_addr)];
        end
        if (s_mem_en) begin
            if (s_mem_we) ram_s[s_mem_addr[4:0]] <= s_mem_wdata;
            else          s_mem_rdata <= ram_s[s_mem_addr[4:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboards and event counters
    always @(negedge clk) begin
        if (b_disp_valid) begin
            check_eq("disp_rsp_expected", 32'(disp_q.size() != 0), 32'd1);
            if (disp_q.size() != 0) check_eq("disp_data", 32'(b_disp_data), 32'(disp_q.pop_front()));
        end
        if (b_rsp_valid) begin
            check_eq("cpu_rsp_expected", 32'(cpu_q.size() != 0), 32'd1);
            if (cpu_q.size() != 0) check_eq("cpu_rsp_data", 32'(b_rsp_data), 32'(cpu_q.pop_front()));
        end
        if (s_clear_busy) s_busy_cycles++;
        if (s_clear_done) s_done_cnt++;
        if (s_clear_busy && s_cpu_ready) s_ready_busy++;
        if (b_clear_done) b_done_cnt++;
        if (b_clear_busy && b_cpu_ready) b_ready_busy++;
        if (b_clear_busy && b_mem_en && b_mem_we) b_clr_writes++;
    end

    task automatic cpu_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [DATA_W-1:0] exp, input logic exp_err);
        int waited = 0;
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        while (!b_cpu_ready && waited < 100) begin
            tick();
            #1;
            waited++;
        end
        check_eq("cpu_accept", 32'(b_cpu_ready), 32'd1);
        check_eq("cpu_mem_en", 32'(b_mem_en), 32'(32'(addr) < FB_DEPTH));
        check_eq("cpu_mem_we", 32'(b_mem_we), 32'(we && (32'(addr) < FB_DEPTH)));
        if (!we) cpu_q.push_back(exp);
        tick();
        cpu_valid = 1'b0; cpu_we = 1'b0;
        check_eq("cpu_err", 32'(b_cpu_err), 32'(exp_err));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int dh[3] = '{640, 0, 639};
        int dv[3] = '{0, 480, 479};
        logic [23:0] dexp[3] = '{24'h0, 24'h0, 24'h13579B};

        reset = 1'b1; disp_req = 1'b0; disp_h = '0; disp_v = '0;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        clear_start = 1'b0; clear_color = '0;
        tick(); tick();
        check_eq("rst_disp_valid", 32'(b_disp_valid), 0);
        check_eq("rst_clear_busy", 32'(b_clear_busy), 0);
        check_eq("rst_clear_done", 32'(b_clear_done), 0);
        check_eq("rst_stall", 32'(b_stall), 0);
        check_eq("rst_rsp_valid", 32'(b_rsp_valid), 0);
        check_eq("rst_cpu_err", 32'(b_cpu_err), 0);
        check_eq("rst_mem_en", 32'(b_mem_en), 0);
        check_eq("rst_cpu_ready", 32'(b_cpu_ready), 0);
        reset = 1'b0;
        #1 check_eq("idle_cpu_ready", 32'(b_cpu_ready), 1);
        tick();

        cpu_txn(1'b1, 19'd1285,   24'hABCDEF, '0, 1'b0);
        cpu_txn(1'b1, 19'd1000,   24'h5A5A5A, '0, 1'b0);
        cpu_txn(1'b1, 19'd307199, 24'h13579B, '0, 1'b0);

        // Display read of (5,2)
        disp_req = 1'b1; disp_h = 10'd5; disp_v = 10'd2;
        disp_q.push_back(24'hABCDEF);
        #1;
        check_eq("disp_mem_addr", 32'(b_mem_addr), 32'd1285);
        check_eq("disp_mem_en", 32'(b_mem_en), 1);
        check_eq("disp_mem_we", 32'(b_mem_we), 0);
        tick();

        // Display and CPU write collide: display wins, CPU holds
        disp_q.push_back(24'hABCDEF);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd10; cpu_wdata = 24'h123456;
        #1;
        check_eq("collide_ready", 32'(b_cpu_ready), 0);
        check_eq("collide_mem_addr", 32'(b_mem_addr), 32'd1285);
        tick();
        check_eq("collide_stall", 32'(b_stall), 1);
        disp_req = 1'b0;
        #1;
        check_eq("held_ready", 32'(b_cpu_ready), 1);
        check_eq("held_mem_we", 32'(b_mem_we), 1);
        check_eq("held_mem_addr", 32'(b_mem_addr), 32'd10);
        tick();
        cpu_valid = 1'b0; cpu_we = 1'b0;
        check_eq("held_stall", 32'(b_stall), 1);
        cpu_txn(1'b0, 19'd10, '0, 24'h123456, 1'b0);

        // Out-of-range CPU accesses and in-range reads
        cpu_txn(1'b1, 19'd307200, 24'h777777, '0, 1'b1);
        cpu_txn(1'b0, 19'd307200, '0, 24'h0, 1'b1);
        cpu_txn(1'b0, 19'd1285, '0, 24'hABCDEF, 1'b0);
        cpu_txn(1'b0, 19'd307199, '0, 24'h13579B, 1'b0);

        // Display range edges
        for (int k = 0; k < 3; k++) begin
            disp_req = 1'b1; disp_h = COORD_W'(dh[k]); disp_v = COORD_W'(dv[k]);
            disp_q.push_back(dexp[k]);
            #1;
            check_eq("disp_edge_mem_en", 32'(b_mem_en), 32'(k == 2));
            tick();
        end
        disp_req = 1'b0;

        // Clear start together with a CPU read
        clear_start = 1'b1; clear_color = GREEN;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd10;
        #1 check_eq("clr_start_cpu_ready", 32'(b_cpu_ready), 1);
        cpu_q.push_back(24'h123456);
        tick();
        clear_start = 1'b0; cpu_valid = 1'b0;
        check_eq("clr_busy_set", 32'(b_clear_busy), 1);
        disp_h = 10'd700; disp_v = 10'd0;
        for (int i = 1; i <= 2000; i++) begin
            disp_req    = i[0];
            clear_start = (i == 10);
            clear_color = (i == 10) ? 24'hFF0000 : GREEN;
            if (disp_req) disp_q.push_back(24'h0);
            tick();
        end
        clear_start = 1'b0; clear_color = '0; disp_req = 1'b0;

        // Reset with the big fill at word 1000
        reset = 1'b1;
        #1;
        check_eq("abort_mem_en", 32'(b_mem_en), 0);
        check_eq("abort_cpu_ready", 32'(b_cpu_ready), 0);
        tick();
        check_eq("abort_busy", 32'(b_clear_busy), 0);
        check_eq("abort_done", 32'(b_clear_done), 0);
        check_eq("abort_disp_valid", 32'(b_disp_valid), 0);
        check_eq("abort_rsp_valid", 32'(b_rsp_valid), 0);
        check_eq("abort_err", 32'(b_cpu_err), 0);
        check_eq("abort_stall", 32'(b_stall), 0);
        check_eq("abort_disp_data", 32'(b_disp_data), 0);
        check_eq("abort_rsp_data", 32'(b_rsp_data), 0);
        reset = 1'b0;
        check_eq("big_clr_writes", 32'(b_clr_writes), 32'd1000);
        check_eq("big_done_cnt", 32'(b_done_cnt), 0);
        check_eq("big_ready_busy", 32'(b_ready_busy), 0);
        check_eq("small_busy_cycles", 32'(s_busy_cycles), 32'(2 * S_DEPTH));
        check_eq("small_done_cnt", 32'(s_done_cnt), 1);
        check_eq("small_ready_busy", 32'(s_ready_busy), 0);
        check_eq("small_ram_first", 32'(ram_s[0]), 32'(GREEN));
        check_eq("small_ram_last", 32'(ram_s[S_DEPTH-1]), 32'(GREEN));
        check_eq("big_ram_1000_kept", 32'(ram_b[1000]), 32'h5A5A5A);
        tick();
        cpu_txn(1'b0, 19'd999, '0, GREEN, 1'b0);
        cpu_txn(1'b0, 19'd1000, '0, 24'h5A5A5A, 1'b0);
        cpu_txn(1'b0, 19'd0, '0, GREEN, 1'b0);

        // Long stall saturates the counter
        disp_req = 1'b1; disp_h = '0; disp_v = '0;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd0;
        for (int i = 1; i <= 70000; i++) begin
            disp_q.push_back(GREEN);
            tick();
            if (i == 100)   check_eq("stall_100", 32'(b_stall), 32'd100);
            if (i == 65535) check_eq("stall_sat", 32'(b_stall), 32'hFFFF);
        end
        check_eq("stall_no_wrap", 32'(b_stall), 32'hFFFF);
        disp_req = 1'b0;
        #1 check_eq("stall_release_ready", 32'(b_cpu_ready), 1);
        cpu_q.push_back(GREEN);
        tick();
        cpu_valid = 1'b0;
        check_eq("stall_hold", 32'(b_stall), 32'hFFFF);
        tick(); tick();
        check_eq("disp_sb_drained", 32'(disp_q.size()), 0);
        check_eq("cpu_sb_drained", 32'(cpu_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
